// File: rtl/gpio_input_conditioner_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
// Provides the legal parameter ranges and the debounce counter width function.
package gpio_cond_pkg;

    localparam int unsigned SYNC_STAGES_MIN     = 2;
    localparam int unsigned SYNC_STAGES_MAX     = 4;
    localparam int unsigned DEBOUNCE_CYCLES_MIN = 1;

    // Bits needed to hold values 0..count, never less than one.
    function automatic int unsigned cnt_width(input int unsigned count);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < (64'(count) + 64'd1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Pin bus between the pad side and the conditioner; master drives the raw
// pads and bypass mask, slave returns debounced levels and edge pulses.
interface gpio_input_conditioner_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] pins_raw;
    logic [WIDTH-1:0] bypass;
    logic [WIDTH-1:0] pins_read;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output pins_raw,
        output bypass,
        input  pins_read,
        input  rise,
        input  fall
    );

    modport slave (
        input  pins_raw,
        input  bypass,
        output pins_read,
        output rise,
        output fall
    );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser chain, stability counter, stable register and
// registered rise/fall edge detector.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic bypass,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable;
    logic                   stable_prev;
    logic [CW-1:0]          cnt;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign level = stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{RESET_VALUE}};
            stable      <= RESET_VALUE;
            stable_prev <= RESET_VALUE;
            cnt         <= '0;
            rise        <= 1'b0;
            fall        <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
            stable_prev <= stable;
            rise        <= stable & ~stable_prev;
            fall        <= ~stable & stable_prev;

            // A returning level or bypass discards any partial count; no resume.
            if (bypass) begin
                stable <= sync;
                cnt    <= '0;
            end else if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Per-bank GPIO input conditioner: one debounce slice per pin, outputs
// gathered back onto the pin bus.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int unsigned      WIDTH           = 12,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                            io_clock,
    input  logic                            io_reset,
    gpio_input_conditioner_if.slave         io
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("gpio_input_conditioner: SYNC_STAGES out of range");
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
        $error("gpio_input_conditioner: DEBOUNCE_CYCLES out of range");
    end

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clk    (io_clock),
            .rst    (io_reset),
            .raw    (io.pins_raw[i]),
            .bypass (io.bypass[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign io.pins_read = level;
    assign io.rise      = rise;
    assign io.fall      = fall;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench: a DEBOUNCE_CYCLES=4 bank for most scenarios and a
// DEBOUNCE_CYCLES=1 bank for the minimum-debounce case.
module tb_gpio_input_conditioner;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gpio_input_conditioner_if #(.WIDTH(12)) dif ();
    gpio_input_conditioner_if #(.WIDTH(12)) mif ();

    gpio_input_conditioner #(
        .WIDTH           (12),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (12'h000)
    ) dut (
        .io_clock (clk),
        .io_reset (rst),
        .io       (dif.slave)
    );

    gpio_input_conditioner #(
        .WIDTH           (12),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_VALUE     (12'h000)
    ) dut_min (
        .io_clock (clk),
        .io_reset (rst),
        .io       (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] er, eu;
        @(negedge clk);
        rst          = 1'b1;
        dif.pins_raw = 12'hFFF;
        dif.bypass   = 12'h000;
        mif.pins_raw = 12'h000;
        mif.bypass   = 12'h000;
        settle(4);
        checks++;
        if (dif.pins_read !== 12'h000 || dif.rise !== 12'h000 || dif.fall !== 12'h000) begin
            errors++;
            $display("FAIL reset_state read=%h rise=%h fall=%h want 000/000/000",
                     dif.pins_read, dif.rise, dif.fall);
        end
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            er = (c >= 6) ? 12'hFFF : 12'h000;
            eu = (c == 7) ? 12'hFFF : 12'h000;
            checks++;
            if (dif.pins_read !== er || dif.rise !== eu || dif.fall !== 12'h000) begin
                errors++;
                $display("FAIL reset_release c=%0d read=%h rise=%h fall=%h want %h/%h/000",
                         c, dif.pins_read, dif.rise, dif.fall, er, eu);
            end
        end
        checks++;
        if (mif.pins_read !== 12'h000 || mif.rise !== 12'h000) begin
            errors++;
            $display("FAIL reset_min read=%h rise=%h want 000/000", mif.pins_read, mif.rise);
        end
    endtask

    task automatic test_clean_edge();
        logic [11:0] er, eu;
        dif.pins_raw = 12'h000;
        settle(12);
        checks++;
        if (dif.pins_read !== 12'h000) begin
            errors++;
            $display("FAIL clean_settle read=%h want 000", dif.pins_read);
        end
        dif.pins_raw = 12'h008;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            er = (c >= 6) ? 12'h008 : 12'h000;
            eu = (c == 7) ? 12'h008 : 12'h000;
            checks++;
            if (dif.pins_read !== er || dif.rise !== eu || dif.fall !== 12'h000) begin
                errors++;
                $display("FAIL clean_edge c=%0d read=%h rise=%h fall=%h want %h/%h/000",
                         c, dif.pins_read, dif.rise, dif.fall, er, eu);
            end
        end
    endtask

    task automatic test_glitch();
        logic [11:0] er, eu;
        logic [15:0] pat;
        pat = 16'b1111_1111_1111_0111;  // bit k = pad level sampled at edge k
        dif.pins_raw = {8'h00, 3'b100, pat[0]};
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            er = (c >= 10) ? 12'h009 : 12'h008;
            eu = (c == 11) ? 12'h001 : 12'h000;
            checks++;
            if (dif.pins_read !== er || dif.rise !== eu || dif.fall !== 12'h000) begin
                errors++;
                $display("FAIL glitch c=%0d read=%h rise=%h fall=%h want %h/%h/000",
                         c, dif.pins_read, dif.rise, dif.fall, er, eu);
            end
            dif.pins_raw = {8'h00, 3'b100, pat[c]};
        end
    endtask

    task automatic test_bypass();
        logic [12:0] rd, ru, fl;
        logic [11:0] er, eu, ef;
        logic        p;
        rd = 13'b0_0110_0110_0110;  // bit c = expected pins_read[0] at cycle c
        ru = 13'b0_0100_0100_0000;
        fl = 13'b1_0001_0001_0000;
        dif.bypass = 12'h001;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                @(negedge clk);
                er = {11'h004, rd[c]};
                eu = {11'h000, ru[c]};
                ef = {11'h000, fl[c]};
                checks++;
                if (dif.pins_read !== er || dif.rise !== eu || dif.fall !== ef) begin
                    errors++;
                    $display("FAIL bypass c=%0d read=%h rise=%h fall=%h want %h/%h/%h",
                             c, dif.pins_read, dif.rise, dif.fall, er, eu, ef);
                end
            end
            p = ((c / 2) % 2) == 1;
            dif.pins_raw = {6'h00, p, 1'b0, 1'b1, 2'b00, p};
        end
        dif.bypass   = 12'h000;
        dif.pins_raw = 12'h808;
        settle(12);
        checks++;
        if (dif.pins_read !== 12'h808) begin
            errors++;
            $display("FAIL bypass_exit read=%h want 808", dif.pins_read);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        logic [11:0] er, eu, ef;
        dif.pins_raw = 12'h009;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            er = (c >= 6) ? 12'h009 : 12'h808;
            eu = (c == 7) ? 12'h001 : 12'h000;
            ef = (c == 7) ? 12'h800 : 12'h000;
            checks++;
            if (dif.pins_read !== er || dif.rise !== eu || dif.fall !== ef) begin
                errors++;
                $display("FAIL simultaneous c=%0d read=%h rise=%h fall=%h want %h/%h/%h",
                         c, dif.pins_read, dif.rise, dif.fall, er, eu, ef);
            end
        end
        dif.pins_raw = 12'h000;
        settle(4);
        checks++;
        if (dif.pins_read !== 12'h009 || dif.fall !== 12'h000) begin
            errors++;
            $display("FAIL midcount_pre read=%h fall=%h want 009/000", dif.pins_read, dif.fall);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.pins_read !== 12'h000 || dif.rise !== 12'h000 || dif.fall !== 12'h000) begin
            errors++;
            $display("FAIL midcount_reset read=%h rise=%h fall=%h want 000/000/000",
                     dif.pins_read, dif.rise, dif.fall);
        end
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (dif.pins_read !== 12'h000 || dif.rise !== 12'h000 || dif.fall !== 12'h000) begin
                errors++;
                $display("FAIL post_reset c=%0d read=%h rise=%h fall=%h want 000/000/000",
                         c, dif.pins_read, dif.rise, dif.fall);
            end
        end
    endtask

    task automatic test_min_debounce();
        logic [10:0] pat, rd, ru, fl;
        logic [11:0] er, eu, ef;
        pat = 11'b000_0001_0010;  // bit k = pad level sampled at edge k
        rd  = 11'b000_1001_0000;
        ru  = 11'b001_0010_0000;
        fl  = 11'b010_0100_0000;
        mif.pins_raw = {9'h000, pat[0], 2'b00};
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            er = {9'h000, rd[c], 2'b00};
            eu = {9'h000, ru[c], 2'b00};
            ef = {9'h000, fl[c], 2'b00};
            checks++;
            if (mif.pins_read !== er || mif.rise !== eu || mif.fall !== ef) begin
                errors++;
                $display("FAIL min_debounce c=%0d read=%h rise=%h fall=%h want %h/%h/%h",
                         c, mif.pins_read, mif.rise, mif.fall, er, eu, ef);
            end
            mif.pins_raw = {9'h000, pat[c], 2'b00};
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        dif.pins_raw = '0;
        dif.bypass   = '0;
        mif.pins_raw = '0;
        mif.bypass   = '0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bypass();
        test_simultaneous_and_reset();
        test_min_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
